cordic_arbiter: RTL and testbench

//  Shares one CORDIC sin/cos engine between NREQ requesters.
//  - Arbitrates pending requests round-robin and launches the engine with the winner's angle.
//  - Waits for the engine's done pulse, then returns cos/sin to the winner only.
//  - Sits between the 16-bit sin/cos datapath and its clients; the engine needs no other sequencer.

---
 rtl/cordic_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/cordic_arbiter.sv | 166 ++++++++++++++++
 tb/tb_cordic_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Brief    : Shared widths, defaults, FSM encoding and angle clamp helper for
//            the CORDIC request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam int ANGLE_W       = 7;
    localparam int DATA_W        = 16;
    localparam int ANGLE_MAX_DEF = 18;
    localparam int TIMEOUT_DEF   = 32;
    localparam int TMR_W         = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } arb_state_t;

    function automatic logic [ANGLE_W-1:0] clamp_angle(
        input logic [ANGLE_W-1:0] z,
        input logic [ANGLE_W-1:0] zmax
    );
        return (z > zmax) ? zmax : z;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational rotate-priority pick: first asserted request
//            searching upward from ptr+1 (mod NREQ); one-hot and index out.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import cordic_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [PTR_W-1:0] grant_idx_o,
    output logic             grant_vld_o
);

    int               w_pos;
    logic [PTR_W-1:0] w_pos_idx;

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        w_pos       = 0;
        w_pos_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_pos     = (int'(ptr_i) + k) % NREQ;
            w_pos_idx = PTR_W'(w_pos);
            if (req_i[w_pos_idx]) begin
                grant_vld_o = 1'b1;
                grant_idx_o = w_pos_idx;
            end
        end
        if (grant_vld_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cordic_arbiter
// Brief    : Shares one CORDIC sin/cos engine between NREQ round-robin clients.
//            Optional macro CORDIC_ARB_TIMEOUT_EN aborts WAIT after TIMEOUT
//            cycles with zero results and timeout_err.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int ANGLE_MAX = ANGLE_MAX_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [ANGLE_W*NREQ-1:0] z0_in,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]       cos_out,
    output logic [DATA_W-1:0]       sin_out,
    output logic                    busy,
    output logic                    core_start,
    output logic [ANGLE_W-1:0]      core_z0,
    input  logic                    core_done,
    input  logic [DATA_W-1:0]       core_cos,
    input  logic [DATA_W-1:0]       core_sin,
    output logic                    timeout_err
);

    localparam int                 PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0]   PTR_RST = PTR_W'(NREQ - 1);
    localparam logic [ANGLE_W-1:0] AMAX    = ANGLE_W'(ANGLE_MAX);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("cordic_arbiter: NREQ must be in 2..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > (1 << TMR_W)) begin : g_bad_timeout
        $error("cordic_arbiter: TIMEOUT must fit the 6-bit WAIT counter");
    end
    if (ANGLE_MAX < 0 || ANGLE_MAX >= (1 << ANGLE_W)) begin : g_bad_amax
        $error("cordic_arbiter: ANGLE_MAX must fit in ANGLE_W bits");
    end

    arb_state_t          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [ANGLE_W-1:0]  z0_q, z0_d;
    logic [DATA_W-1:0]   cos_q, cos_d;
    logic [DATA_W-1:0]   sin_q, sin_d;

    logic [NREQ-1:0]     w_grant;
    logic [PTR_W-1:0]    w_grant_idx;
    logic                w_grant_vld;
    logic [ANGLE_W-1:0]  w_z0_sel;
    logic                w_timeout;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .grant_o     (w_grant),
        .grant_idx_o (w_grant_idx),
        .grant_vld_o (w_grant_vld)
    );

    always_comb begin
        w_z0_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_z0_sel = z0_in[i*ANGLE_W +: ANGLE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        z0_d    = z0_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        case (state_q)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    state_d = ST_ISSUE;
                    ptr_d   = w_grant_idx;
                    z0_d    = clamp_angle(w_z0_sel, AMAX);
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    state_d = ST_DELIVER;
                    cos_d   = core_cos;
                    sin_d   = core_sin;
                end else if (w_timeout) begin
                    state_d = ST_DELIVER;
                    cos_d   = '0;
                    sin_d   = '0;
                end
            end
            ST_DELIVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_RST;
            z0_q    <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            z0_q    <= z0_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] tmr_q;
    logic             to_q;

    // Counter sits at zero outside WAIT, so it restarts on every WAIT entry.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            tmr_q <= '0;
            to_q  <= 1'b0;
        end else begin
            tmr_q <= (state_q == ST_WAIT) ? tmr_q + 1'b1 : '0;
            to_q  <= (state_q == ST_WAIT) && w_timeout && !core_done;
        end
    end

    assign w_timeout   = (state_q == ST_WAIT) && (tmr_q == TMR_LAST);
    assign timeout_err = (state_q == ST_DELIVER) && to_q;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Gated by reset so nothing looks accepted while the FSM is held.
    assign ack        = (state_q == ST_IDLE && !reset) ? w_grant : '0;
    assign rsp_valid  = (state_q == ST_DELIVER) ? (NREQ'(1) << ptr_q) : '0;
    assign busy       = (state_q != ST_IDLE);
    assign core_start = (state_q == ST_ISSUE);
    assign core_z0    = z0_q;
    assign cos_out    = cos_q;
    assign sin_out    = sin_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_arbiter
// Brief    : Randomised self-checking bench for cordic_arbiter against a
//            transaction-level round-robin model and a sin/cos engine model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_arbiter;

    localparam int NREQ = 4;
    localparam int AMAX = 18;
    localparam int TMO  = 32;

    logic                 CLK = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [7*NREQ-1:0]    z0_in = '0;
    logic                 core_done = 1'b0;
    logic [15:0]          core_cos = '0;
    logic [15:0]          core_sin = '0;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      rsp_valid;
    logic [15:0]          cos_out;
    logic [15:0]          sin_out;
    logic                 busy;
    logic                 core_start;
    logic [6:0]           core_z0;
    logic                 timeout_err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          last_grant = NREQ - 1;
    logic [15:0] hold_cos = '0;
    logic [15:0] hold_sin = '0;

    cordic_arbiter #(.NREQ(NREQ), .ANGLE_MAX(AMAX), .TIMEOUT(TMO)) u_dut (
        .CLK         (CLK),
        .reset       (reset),
        .req         (req),
        .z0_in       (z0_in),
        .ack         (ack),
        .rsp_valid   (rsp_valid),
        .cos_out     (cos_out),
        .sin_out     (sin_out),
        .busy        (busy),
        .core_start  (core_start),
        .core_z0     (core_z0),
        .core_done   (core_done),
        .core_cos    (core_cos),
        .core_sin    (core_sin),
        .timeout_err (timeout_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] rq);
        int i;
        for (int k = 1; k <= NREQ; k++) begin
            i = (last_grant + k) % NREQ;
            if (rq[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] ecos(input logic [6:0] z);
        real a;
        a = real'(z) * 5.0 * 3.141592653589793 / 180.0;
        return 16'($rtoi(16384.0 * $cos(a)));
    endfunction

    function automatic logic [15:0] esin(input logic [6:0] z);
        real a;
        a = real'(z) * 5.0 * 3.141592653589793 / 180.0;
        return 16'($rtoi(16384.0 * $sin(a)));
    endfunction

    task automatic chk_zero(input string pfx);
        chk({pfx, "_ack"}, 32'(ack), 0);
        chk({pfx, "_rsp"}, 32'(rsp_valid), 0);
        chk({pfx, "_cos"}, 32'(cos_out), 0);
        chk({pfx, "_sin"}, 32'(sin_out), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_start"}, 32'(core_start), 0);
        chk({pfx, "_z0"}, 32'(core_z0), 0);
        chk({pfx, "_terr"}, 32'(timeout_err), 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b1;
        req = '0;
        core_done = 1'b0;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        last_grant = NREQ - 1;
        hold_cos = '0;
        hold_sin = '0;
    endtask

    // One arbitration round; returns the observed ack vector.
    task automatic xact(input logic [NREQ-1:0] rq, input logic [7*NREQ-1:0] zb,
                        input int lat, input bit pre_done, output logic [NREQ-1:0] got_ack);
        int          w_exp;
        logic [6:0]  ez;
        logic [15:0] ec, es;
        w_exp = model_pick(rq);
        @(negedge CLK);
        req = rq;
        z0_in = zb;
        #1;
        got_ack = ack;
        chk("idle_busy", 32'(busy), 0);
        chk("ack", 32'(ack), (w_exp < 0) ? 32'd0 : (32'd1 << w_exp));
        if (w_exp < 0) return;
        last_grant = w_exp;
        ez = 7'(zb >> (7 * w_exp));
        if (int'(ez) > AMAX) ez = 7'(AMAX);
        ec = ecos(ez);
        es = esin(ez);
        @(negedge CLK);
        req = NREQ'($urandom);
        z0_in = (7*NREQ)'($urandom);
        if (pre_done) begin
            core_done = 1'b1;
            core_cos = 16'($urandom);
            core_sin = 16'($urandom);
        end
        #1;
        chk("start", 32'(core_start), 1);
        chk("core_z0", 32'(core_z0), 32'(ez));
        chk("ack_issue", 32'(ack), 0);
        chk("busy_issue", 32'(busy), 1);
        @(negedge CLK);
        core_done = 1'b0;
        for (int w = 1; w <= lat; w++) begin
            if (w > 1) @(negedge CLK);
            #1;
            chk("wait_start", 32'(core_start), 0);
            chk("wait_rsp", 32'(rsp_valid), 0);
            chk("wait_z0", 32'(core_z0), 32'(ez));
            if (w == lat) begin
                core_done = 1'b1;
                core_cos = ec;
                core_sin = es;
            end
        end
        @(negedge CLK);
        core_done = 1'b0;
        core_cos = 16'($urandom);
        core_sin = 16'($urandom);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1 << w_exp);
        chk("cos_out", 32'(cos_out), 32'(ec));
        chk("sin_out", 32'(sin_out), 32'(es));
        chk("terr", 32'(timeout_err), 0);
        chk("ack_deliver", 32'(ack), 0);
        hold_cos = ec;
        hold_sin = es;
    endtask

    logic [NREQ-1:0]   ga;
    logic [NREQ-1:0]   rq;
    logic [7*NREQ-1:0] zb;

    initial begin
        // reset state
        @(negedge CLK);
        #1;
        chk_zero("rst");
        repeat (2) @(negedge CLK);
        reset = 1'b0;

        // single client, 30 degrees, 13-cycle engine
        zb = '0;
        zb[6:0] = 7'd6;
        xact(4'b0001, zb, 13, 1'b0, ga);
        chk("t1_ack", 32'(ga), 32'h1);
        @(negedge CLK);
        req = '0;
        #1;
        chk("t1_ack_once", 32'(ack), 0);

        // all clients held: strict rotation from client 0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            xact(4'hF, (7*NREQ)'($urandom), $urandom_range(1, 15), 1'b0, ga);
            chk("fair_order", 32'(ga), 32'd1 << (i % NREQ));
        end

        // out-of-range angle clamped, then the direct maximum
        zb = '0;
        zb[20:14] = 7'd25;
        xact(4'b0100, zb, 13, 1'b0, ga);
        chk("t3_ack", 32'(ga), 32'h4);
        zb[20:14] = 7'd18;
        xact(4'b0100, zb, 13, 1'b0, ga);
        chk("t3_ack_direct", 32'(ga), 32'h4);

        // a lone continuous requester is served every round
        for (int i = 0; i < 3; i++) begin
            xact(4'b0010, (7*NREQ)'($urandom), $urandom_range(1, 6), 1'b1, ga);
            chk("single_served", 32'(ga), 32'h2);
        end

        // core_done in IDLE is ignored
        @(negedge CLK);
        req = '0;
        core_done = 1'b1;
        core_cos = 16'h7777;
        core_sin = 16'h5555;
        #1;
        chk("t6_idle_busy", 32'(busy), 0);
        @(negedge CLK);
        core_done = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_rsp", 32'(rsp_valid), 0);
        chk("t6_cos_hold", 32'(cos_out), 32'(hold_cos));
        chk("t6_sin_hold", 32'(sin_out), 32'(hold_sin));

        // reset during WAIT, late core_done ignored
        do_reset();
        @(negedge CLK);
        req = 4'b0001;
        z0_in = 28'd6;
        #1;
        chk("t4_ack", 32'(ack), 32'h1);
        @(negedge CLK);
        req = '0;
        #1;
        chk("t4_start", 32'(core_start), 1);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        #1;
        chk_zero("t4_rst_a");
        @(negedge CLK);
        #1;
        chk_zero("t4_rst_b");
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        core_done = 1'b1;
        core_cos = 16'h1234;
        core_sin = 16'h4321;
        repeat (3) begin
            @(negedge CLK);
            core_done = 1'b0;
            #1;
            chk("t4_no_rsp", 32'(rsp_valid), 0);
            chk("t4_busy", 32'(busy), 0);
            chk("t4_cos", 32'(cos_out), 0);
        end
        last_grant = NREQ - 1;
        zb = '0;
        zb[13:7] = 7'd9;
        xact(4'b0010, zb, 4, 1'b0, ga);
        chk("t4_after", 32'(ga), 32'h2);

        // randomised traffic
        for (int t = 0; t < 40; t++) begin
            rq = NREQ'($urandom);
            zb = (7*NREQ)'($urandom);
            xact(rq, zb, $urandom_range(1, 15), ($urandom_range(0, 3) == 0), ga);
        end

`ifdef CORDIC_ARB_TIMEOUT_EN
        begin
            int w_exp;
            zb = '0;
            zb[13:7] = 7'd6;
            xact(4'b0010, zb, 3, 1'b0, ga);
            w_exp = model_pick(4'b0010);
            @(negedge CLK);
            req = 4'b0010;
            #1;
            chk("t5_ack", 32'(ack), 32'd1 << w_exp);
            last_grant = w_exp;
            @(negedge CLK);
            req = '0;
            #1;
            chk("t5_start", 32'(core_start), 1);
            for (int w = 1; w <= TMO; w++) begin
                @(negedge CLK);
                #1;
                chk("t5_wait_rsp", 32'(rsp_valid), 0);
            end
            @(negedge CLK);
            #1;
            chk("t5_rsp", 32'(rsp_valid), 32'd1 << w_exp);
            chk("t5_terr", 32'(timeout_err), 1);
            chk("t5_cos", 32'(cos_out), 0);
            chk("t5_sin", 32'(sin_out), 0);
            @(negedge CLK);
            #1;
            chk("t5_terr_clr", 32'(timeout_err), 0);
        end
`endif

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
